// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I execute stage: operand latching,
// MEM/WB forwarding, ALU source muxing and load-use bubble insertion.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [3:0]      id_alu_ctrl,
  input  logic [1:0]      id_src_sel,
  input  logic [2:0]      id_ctrl,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_srcA,
  output logic [XLEN-1:0] ex_srcB,
  output logic [3:0]      ex_alu_ctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic [2:0]      ex_ctrl
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [RA_W-1:0] r_rs1_addr;
  logic [RA_W-1:0] r_rs2_addr;
  logic [RA_W-1:0] r_rd_addr;
  logic [3:0]      r_alu_ctrl;
  logic [1:0]      r_src_sel;
  logic [2:0]      r_ctrl;

  logic            w_load_use;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  // r_ctrl[1] is mem_read: a load in EX whose rd is needed by ID.
  always_comb begin
    w_load_use = r_valid && r_ctrl[1] && (r_rd_addr != '0) && id_valid &&
                 ((id_rs1_addr == r_rd_addr) || (id_rs2_addr == r_rd_addr));
  end

  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && w_load_use)) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_alu_ctrl <= '0;
      r_src_sel  <= '0;
      r_ctrl     <= '0;
    end else if (!stall) begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1_addr <= id_rs1_addr;
      r_rs2_addr <= id_rs2_addr;
      r_rd_addr  <= id_rd_addr;
      r_alu_ctrl <= id_alu_ctrl;
      r_src_sel  <= id_src_sel;
      r_ctrl     <= id_ctrl;
    end
  end

  // MEM is younger than WB, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (mem_reg_write && (mem_rd_addr == r_rs1_addr) && (r_rs1_addr != '0))
      w_fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd_addr == r_rs1_addr) && (r_rs1_addr != '0))
      w_fwd_rs1 = wb_result;

    w_fwd_rs2 = r_rs2_data;
    if (mem_reg_write && (mem_rd_addr == r_rs2_addr) && (r_rs2_addr != '0))
      w_fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd_addr == r_rs2_addr) && (r_rs2_addr != '0))
      w_fwd_rs2 = wb_result;
  end

  assign load_use_stall = w_load_use;
  assign ex_valid       = r_valid;
  assign ex_srcA        = r_src_sel[1] ? r_pc  : w_fwd_rs1;
  assign ex_srcB        = r_src_sel[0] ? r_imm : w_fwd_rs2;
  assign ex_store_data  = w_fwd_rs2;
  assign ex_alu_ctrl    = r_alu_ctrl;
  assign ex_rd_addr     = r_rd_addr;
  assign ex_ctrl        = r_ctrl;

endmodule

// File: doc/id_ex_stage.md
Name:
id_ex_stage

Overview:
Decode-to-execute pipeline register feeding the RV32I ALU: latches decoded operands/controls, applies MEM/WB operand forwarding, and drives srcA/srcB/ALUControl. Detects load-use hazards, requests an upstream freeze and inserts a bubble into EX.

Parameters:
XLEN, 32, datapath width (ALU is fixed at 32)
RA_W, 5, register address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  external freeze: hold every register
flush  in  1  branch/jump redirect: load bubble
id_valid  in  1  decode slot holds a real instruction
id_pc  in  XLEN  PC of decoded instruction
id_rs1_data  in  XLEN  register file read port 1
id_rs2_data  in  XLEN  register file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1_addr  in  RA_W  rs1 index
id_rs2_addr  in  RA_W  rs2 index
id_rd_addr  in  RA_W  rd index
id_alu_ctrl  in  4  ALU op (0000 ADD ... 1001 SRA)
id_src_sel  in  2  [1]=srcA takes PC, [0]=srcB takes imm
id_ctrl  in  3  {reg_write, mem_read, mem_write}
mem_reg_write  in  1  MEM-stage instruction writes rd
mem_rd_addr  in  RA_W  MEM-stage rd
mem_result  in  XLEN  MEM-stage ALU result
wb_reg_write  in  1  WB-stage instruction writes rd
wb_rd_addr  in  RA_W  WB-stage rd
wb_result  in  XLEN  WB-stage writeback value
load_use_stall  out  1  freeze IF/ID this cycle (combinational)
ex_valid  out  1  EX slot valid
ex_srcA  out  XLEN  ALU operand A
ex_srcB  out  XLEN  ALU operand B
ex_alu_ctrl  out  4  ALU op to ALU
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_rd_addr  out  RA_W  registered rd
ex_ctrl  out  3  registered {reg_write, mem_read, mem_write}

Behaviour:
- Registered fields: valid, pc, rs1_data, rs2_data, imm, rs1/rs2/rd addr, alu_ctrl, src_sel, ctrl. On rst all are 0, so ex_valid=0, ex_ctrl=000, ex_alu_ctrl=0000 (ADD), and ex_srcA/ex_srcB/ex_store_data=0 unless forwarding matches (rs addr 0 never forwards).
- Bubble: valid=0, ctrl=000, alu_ctrl=0000, rd=0. Data fields are don't-care, but the implementation zeroes them.
- Per-edge priority: rst > flush (load bubble) > stall (hold all) > load_use_stall (load bubble) > normal (load id_* inputs).
- load_use_stall = ex_valid & ex_ctrl[1] & ex_rd_addr!=0 & id_valid & (id_rs1_addr==ex_rd_addr | id_rs2_addr==ex_rd_addr). It is asserted regardless of the stall/flush inputs; the upstream stage combines them.
- Forwarding, combinational on registered rsN: if mem_reg_write & mem_rd_addr==rsN & rsN!=0, use mem_result; else if wb_reg_write & wb_rd_addr==rsN & rsN!=0, use wb_result; else the registered data. MEM has priority over WB.
- ex_srcA = src_sel[1] ? pc : fwd_rs1. ex_srcB = src_sel[0] ? imm : fwd_rs2. ex_store_data = fwd_rs2 always.
- Latency: one cycle from id_* to ex_*. Forwarding adds no cycle. A load-use dependency costs exactly one bubble cycle.
- A flush during load_use_stall still produces a bubble, and upstream discards ID. An instruction held by stall keeps re-evaluating forwarding each cycle.

Test Plan:
- rst=1 for 2 cycles -> ex_valid=0, ex_ctrl=000, ex_alu_ctrl=0000, ex_srcA=ex_srcB=0. Release, then load ADD x3,x1,x2 (rs1=5, rs2=7) -> next cycle ex_srcA=5, ex_srcB=7, ex_valid=1.
- EX rs1=x4, mem_rd=x4 (mem_result=0xAAAA), wb_rd=x4 (wb_result=0xBBBB), both reg_write=1 -> ex_srcA=0xAAAA. Drop mem_reg_write -> ex_srcA=0xBBBB.
- EX rs1=x0 with mem_rd=x0, mem_reg_write=1, mem_result=0xFFFF -> ex_srcA = registered value 0.
- EX holds LW x5; ID holds ADD x6,x5,x1 -> load_use_stall=1, next cycle ex_valid=0/ex_ctrl=000. Following cycle the ADD enters with load_use_stall=0.
- stall=1 for 3 cycles with changing id_* -> ex_* outputs unchanged. flush=1 together with stall=1 -> bubble loaded next edge.
